// File: rtl/note_record_sequencer_if.sv
// Write-port bundle between the note record sequencer and port A of the note RAM.
interface note_record_sequencer_if #(
  parameter int NUM_MEASURES = 20,
  parameter int NOTE_W       = 6
);
  localparam int ADDR_W = (NUM_MEASURES > 1) ? $clog2(NUM_MEASURES) : 1;

  logic [ADDR_W-1:0]   mem_addr_out;
  logic [8*NOTE_W-1:0] mem_din_out;
  logic                mem_we_out;

  modport master (output mem_addr_out, output mem_din_out, output mem_we_out);
  modport slave  (input  mem_addr_out, input  mem_din_out, input  mem_we_out);
endinterface

// File: rtl/note_record_sequencer.sv
// Clears the note memory, then packs one note code per eighth tick into measure words.
// Optional metronome click output is enabled by defining NOTE_RECORD_METRONOME_EN.
module note_record_sequencer #(
  parameter int TICKS_PER_EIGHTH = 37125000,
  parameter int NUM_MEASURES     = 20,
  parameter int NOTE_W           = 6
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic              toggle_in,
  input  logic [NOTE_W-1:0] note_in,
  note_record_sequencer_if.master mem_if,
  output logic [7:0]        eighth_dex_out,
  output logic [1:0]        state_out,
  output logic              measure_done_out,
  output logic              click_out
);

  localparam int ADDR_W = (NUM_MEASURES > 1) ? $clog2(NUM_MEASURES) : 1;
  localparam int CNT_W  = (TICKS_PER_EIGHTH > 1) ? $clog2(TICKS_PER_EIGHTH) : 1;
  localparam int WORD_W = 8 * NOTE_W;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICKS_PER_EIGHTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_MEASURES - 1);
  localparam logic [7:0]        DEX_LAST  = 8'(8 * NUM_MEASURES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_RECORD = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_toggle_q;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [7:0]          r_dex, w_dex_next;
  logic [WORD_W-1:0]   r_shadow, w_shadow_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [WORD_W-1:0]   r_din, w_din_next;
  logic                r_we, w_we_next;
  logic                r_done, w_done_next;
  logic                w_rise;
  logic                w_tick;
  logic [WORD_W-1:0]   w_merged;

  assign w_rise = toggle_in & ~r_toggle_q;
  assign w_tick = (r_state == S_RECORD) && (r_cnt == CNT_LAST);

  // Shadow word with the current note dropped into the slot selected by dex[2:0].
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      assign w_merged[NOTE_W*gi +: NOTE_W] =
        (r_dex[2:0] == 3'(gi)) ? note_in : r_shadow[NOTE_W*gi +: NOTE_W];
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_dex_next    = r_dex;
    w_shadow_next = r_shadow;
    w_addr_next   = r_addr;
    w_din_next    = r_din;
    w_we_next     = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      S_IDLE, S_FULL: begin
        if (w_rise) begin
          w_state_next = S_CLEAR;
          w_addr_next  = '0;
          w_din_next   = '0;
          w_we_next    = 1'b1;
        end
      end
      S_CLEAR: begin
        if (!toggle_in) begin
          w_state_next = S_IDLE;
        end else if (r_addr == ADDR_LAST) begin
          w_state_next  = S_RECORD;
          w_cnt_next    = '0;
          w_dex_next    = '0;
          w_shadow_next = '0;
        end else begin
          w_addr_next = r_addr + ADDR_W'(1);
          w_din_next  = '0;
          w_we_next   = 1'b1;
        end
      end
      S_RECORD: begin
        // Abort wins over a coinciding tick, so the pending write never appears.
        if (!toggle_in) begin
          w_state_next = S_IDLE;
        end else if (w_tick) begin
          w_cnt_next    = '0;
          w_addr_next   = r_dex[ADDR_W+2:3];
          w_din_next    = w_merged;
          w_we_next     = 1'b1;
          w_dex_next    = r_dex + 8'd1;
          w_done_next   = (r_dex[2:0] == 3'd7);
          w_shadow_next = (r_dex[2:0] == 3'd7) ? '0 : w_merged;
          if (r_dex == DEX_LAST) begin
            w_state_next = S_FULL;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_toggle_q <= 1'b0;
      r_cnt      <= '0;
      r_dex      <= '0;
      r_shadow   <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_toggle_q <= toggle_in;
      r_cnt      <= w_cnt_next;
      r_dex      <= w_dex_next;
      r_shadow   <= w_shadow_next;
      r_addr     <= w_addr_next;
      r_din      <= w_din_next;
      r_we       <= w_we_next;
      r_done     <= w_done_next;
    end
  end

`ifdef NOTE_RECORD_METRONOME_EN
  logic r_entry;

  // Count-in marker lands in the first RECORD cycle.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_entry <= 1'b0;
    end else begin
      r_entry <= (r_state == S_CLEAR) && (w_state_next == S_RECORD);
    end
  end

  assign click_out = r_entry | (w_tick & ~r_dex[0]);
`else
  assign click_out = 1'b0;
`endif

  assign mem_if.mem_addr_out = r_addr;
  assign mem_if.mem_din_out  = r_din;
  assign mem_if.mem_we_out   = r_we;
  assign eighth_dex_out      = r_dex;
  assign state_out           = r_state;
  assign measure_done_out    = r_done;

endmodule

// File: tb/tb_note_record_sequencer.sv
// Directed bench: dut_a (4 ticks/eighth, 20 measures) and dut_b (1 tick/eighth, 2 measures).
module tb_note_record_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       toggle_a, toggle_b;
  logic [5:0] note_a, note_b;
  logic [7:0] dex_a, dex_b;
  logic [1:0] st_a, st_b;
  logic       done_a, done_b, click_a, click_b;

  always #5 clk = ~clk;

  note_record_sequencer_if #(.NUM_MEASURES(20), .NOTE_W(6)) if_a ();
  note_record_sequencer_if #(.NUM_MEASURES(2),  .NOTE_W(6)) if_b ();

  note_record_sequencer #(.TICKS_PER_EIGHTH(4), .NUM_MEASURES(20), .NOTE_W(6)) dut_a (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .toggle_in(toggle_a), .note_in(note_a),
    .mem_if(if_a), .eighth_dex_out(dex_a), .state_out(st_a),
    .measure_done_out(done_a), .click_out(click_a)
  );

  note_record_sequencer #(.TICKS_PER_EIGHTH(1), .NUM_MEASURES(2), .NOTE_W(6)) dut_b (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .toggle_in(toggle_b), .note_in(note_b),
    .mem_if(if_b), .eighth_dex_out(dex_b), .state_out(st_b),
    .measure_done_out(done_b), .click_out(click_b)
  );

`ifdef NOTE_RECORD_METRONOME_EN
  localparam int EXP_ENTRY_CLICK = 1;
  localparam int EXP_MEAS_CLICKS = 5;
`else
  localparam int EXP_ENTRY_CLICK = 0;
  localparam int EXP_MEAS_CLICKS = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int clicks, dones, writes, writes_b;
  logic [5:0]  notes [8] = '{6'd33, 6'd35, 6'd0, 6'd38, 6'd40, 6'd42, 6'd45, 6'd47};
  logic [47:0] exp_word;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", tag, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, act);
    end
  endtask

  task automatic step_a();
    @(negedge clk);
    if (click_a) clicks++;
    if (done_a) dones++;
    if (if_a.mem_we_out) writes++;
  endtask

  initial begin
    rst_n = 1'b0; toggle_a = 1'b0; toggle_b = 1'b0; note_a = '0; note_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", st_a, 0);
    check("rst_we", if_a.mem_we_out, 0);
    check("rst_dex", dex_a, 0);
    check("rst_addr", if_a.mem_addr_out, 0);
    check("rst_din", if_a.mem_din_out, 0);
    check("rst_done", done_a, 0);
    check("rst_click", click_a, 0);
    check("rst_state_b", st_b, 0);

    // Clear sweep: 20 consecutive zero writes, then RECORD
    toggle_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("clr_we[%0d]", i), if_a.mem_we_out, 1);
      check($sformatf("clr_addr[%0d]", i), if_a.mem_addr_out, i);
      check($sformatf("clr_din[%0d]", i), if_a.mem_din_out, 0);
    end
    @(negedge clk);
    check("rec_state", st_a, 2);
    check("rec_we", if_a.mem_we_out, 0);
    check("rec_entry_click", click_a, EXP_ENTRY_CLICK);

    // Packing of one measure
    clicks = click_a ? 1 : 0; dones = 0; writes = 0; exp_word = '0;
    for (int k = 0; k < 8; k++) begin
      note_a = notes[k];
      repeat (4) step_a();
      exp_word[6*k +: 6] = notes[k];
      check($sformatf("pk_we[%0d]", k), if_a.mem_we_out, 1);
      check($sformatf("pk_addr[%0d]", k), if_a.mem_addr_out, 0);
      check($sformatf("pk_din[%0d]", k), if_a.mem_din_out, exp_word);
      check($sformatf("pk_dex[%0d]", k), dex_a, k + 1);
    end
    check("pk_final", if_a.mem_din_out,
          {6'd47, 6'd45, 6'd42, 6'd40, 6'd38, 6'd0, 6'd35, 6'd33});
    check("pk_done_now", done_a, 1);
    check("pk_done_count", dones, 1);
    check("pk_writes", writes, 8);
    check("pk_clicks", clicks, EXP_MEAS_CLICKS);

    // Ninth write opens measure 1 with fresh upper slots
    note_a = 6'd9;
    repeat (4) step_a();
    check("m1_we", if_a.mem_we_out, 1);
    check("m1_addr", if_a.mem_addr_out, 1);
    check("m1_din", if_a.mem_din_out, 48'd9);
    check("m1_done", done_a, 0);
    check("m1_dex", dex_a, 9);

    // Abort on a tick cycle: the following write is suppressed
    repeat (3) step_a();
    toggle_a = 1'b0; writes = 0;
    step_a();
    check("ab_state", st_a, 0);
    check("ab_we", if_a.mem_we_out, 0);
    check("ab_dex", dex_a, 9);
    repeat (3) step_a();
    check("ab_no_writes", writes, 0);

    // Restart, record to dex=5, abort again
    toggle_a = 1'b1;
    step_a();
    check("rs_state", st_a, 1);
    check("rs_addr", if_a.mem_addr_out, 0);
    check("rs_we", if_a.mem_we_out, 1);
    repeat (20) step_a();
    check("rs_rec_state", st_a, 2);
    check("rs_rec_dex", dex_a, 0);
    for (int k = 0; k < 5; k++) begin
      note_a = 6'(k + 1);
      repeat (4) step_a();
    end
    check("ab5_dex_before", dex_a, 5);
    repeat (3) step_a();
    toggle_a = 1'b0;
    step_a();
    check("ab5_state", st_a, 0);
    check("ab5_we", if_a.mem_we_out, 0);
    check("ab5_dex", dex_a, 5);

    // Fill on dut_b: 2 clear writes + 16 record writes, then FULL
    note_b = 6'd7; toggle_b = 1'b1; writes_b = 0;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (if_b.mem_we_out) writes_b++;
      if (s == 19) begin
        check("fill_state", st_b, 3);
        check("fill_dex", dex_b, 16);
        check("fill_last_we", if_b.mem_we_out, 1);
        check("fill_last_addr", if_b.mem_addr_out, 1);
        check("fill_last_din", if_b.mem_din_out, {8{6'd7}});
      end
    end
    check("fill_writes", writes_b, 18);
    check("fill_state_end", st_b, 3);
    check("fill_dex_end", dex_b, 16);
    toggle_b = 1'b0;
    repeat (2) @(negedge clk);
    toggle_b = 1'b1;
    @(negedge clk);
    check("full_restart", st_b, 1);
    toggle_b = 1'b0;

    // Asynchronous reset in the middle of a RECORD write cycle
    toggle_a = 1'b1;
    repeat (21) step_a();
    repeat (4) step_a();
    check("pre_rst_we", if_a.mem_we_out, 1);
    check("pre_rst_dex", dex_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", st_a, 0);
    check("arst_we", if_a.mem_we_out, 0);
    check("arst_dex", dex_a, 0);
    @(negedge clk);
    rst_n = 1'b1; toggle_a = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
